pipeline_stall_controller: RTL and testbench

- Central hazard sequencer for the 5-stage MIPS pipeline.
- Combines three hazard sources into one set of pipeline-register control strobes:
  - load-use detection between ID/EX and IF/ID,
  - taken-branch flush from EX,
  - interlock for the multi-cycle multiply unit (HI/LO).
- Also keeps saturating stall and flush performance counters for debug.

---
 rtl/pipeline_stall_controller.sv | 168 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central hazard sequencer for the 5-stage MIPS pipeline. It merges three
//   hazard sources into one set of pipeline-register strobes:
//     - load-use between the load in EX (ID/EX) and the instruction in ID,
//     - taken-branch / jump flush resolved in EX,
//     - interlock on HI/LO while the multi-cycle multiply unit is busy.
//   It also keeps saturating stall and flush counters for debug.
//
// Parameters
//   MULT_LATENCY  cycles the multiply unit stays busy after a mult enters EX (2..15)
//   CNT_W         width of the performance counters
//
// Ports
//   Clk, Rst_n        clock, asynchronous active-low reset
//   IDEX_MemRead      instruction in EX is a load
//   IDEX_RegisterRt   destination register of that load
//   IFID_Rs/Rt        source register fields of the instruction in ID
//   IFID_UsesRt       ID instruction reads rt as a source
//   IFID_UsesHiLo     ID instruction is mfhi/mflo
//   IFID_IsMult       ID instruction is mult/multu
//   EX_MultStart      a valid mult is in EX this cycle
//   EX_BranchTaken    branch/jump in EX resolved taken
//   PCWrite           PC register enable
//   IFIDWrite         IF/ID register enable
//   IFIDFlush         zero IF/ID on the next edge
//   IDEXBubble        zero ID/EX control bits on the next edge
//   MultBusy          multiply unit occupied
//   StallCycles       saturating count of stall cycles
//   FlushCount        saturating count of taken-branch flushes
//
// The strobes are same-cycle combinational functions of the hazard inputs,
// because the pipeline registers they gate sample on the very next edge.

module pipeline_stall_controller #(
    parameter int unsigned MULT_LATENCY = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_RegisterRt,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_UsesHiLo,
    input  logic             IFID_IsMult,
    input  logic             EX_MultStart,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             MultBusy,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned MCNT_W = 4;
    localparam logic [MCNT_W-1:0] MULT_RELOAD = MCNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    typedef enum logic {
        RUN       = 1'b0,
        MULT_BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [MCNT_W-1:0] multCnt;
    logic [MCNT_W-1:0] multCntNext;

    logic loadUse;
    logic multLock;
    logic stallEvent;
    logic flushEvent;

    // Load-use: register $0 never carries a real dependency.
    assign loadUse = IDEX_MemRead
                  && (IDEX_RegisterRt != 5'd0)
                  && ((IDEX_RegisterRt == IFID_Rs)
                      || (IFID_UsesRt && (IDEX_RegisterRt == IFID_Rt)));

    assign multLock = (state == MULT_BUSY) && (IFID_UsesHiLo || IFID_IsMult);

    // A taken branch squashes the ID instruction, so its hazards do not stall.
    assign stallEvent = Rst_n && !EX_BranchTaken && (loadUse || multLock);
    assign flushEvent = Rst_n && EX_BranchTaken;

    // State and multiply-latency counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= RUN;
            multCnt <= '0;
        end else begin
            state   <= stateNext;
            multCnt <= multCntNext;
        end
    end

    // Next state and pipeline strobes.
    always_comb begin
        stateNext   = state;
        multCntNext = multCnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        MultBusy    = (state == MULT_BUSY);

        unique case (state)
            RUN: begin
                if (EX_MultStart) begin
                    stateNext   = MULT_BUSY;
                    multCntNext = MULT_RELOAD;
                end
            end
            MULT_BUSY: begin
                // A new mult restarts the latency even on the final busy cycle.
                if (EX_MultStart) begin
                    multCntNext = MULT_RELOAD;
                end else if (multCnt == '0) begin
                    stateNext = RUN;
                end else begin
                    multCntNext = multCnt - MCNT_W'(1);
                end
            end
            default: begin
                stateNext   = RUN;
                multCntNext = '0;
            end
        endcase

        if (!Rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b0;
            IDEXBubble = 1'b1;
            MultBusy   = 1'b0;
        end else if (EX_BranchTaken) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (loadUse || multLock) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    // Saturating debug counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (stallEvent && (StallCycles != CNT_MAX)) begin
                StallCycles <= StallCycles + CNT_ONE;
            end
            if (flushEvent && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: the stimulus process pushes
// the reference model's expected strobes/counters each cycle, and a monitor
// process pops and compares them against the DUT before the next edge.

module tb_pipeline_stall_controller;

    localparam int unsigned ML  = 4;
    localparam int unsigned CW  = 4;
    localparam int          MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic       rstn;
        logic       memRead;
        logic [4:0] idexRt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       usesHiLo;
        logic       isMult;
        logic       multStart;
        logic       branch;
    } stim_t;

    typedef struct packed {
        logic [4:0]    ctl;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MultBusy}
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    logic          Clk;
    logic          Rst_n;
    logic          IDEX_MemRead;
    logic [4:0]    IDEX_RegisterRt;
    logic [4:0]    IFID_Rs;
    logic [4:0]    IFID_Rt;
    logic          IFID_UsesRt;
    logic          IFID_UsesHiLo;
    logic          IFID_IsMult;
    logic          EX_MultStart;
    logic          EX_BranchTaken;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          IFIDFlush;
    logic          IDEXBubble;
    logic          MultBusy;
    logic [CW-1:0] StallCycles;
    logic [CW-1:0] FlushCount;

    pipeline_stall_controller #(
        .MULT_LATENCY(ML),
        .CNT_W       (CW)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegisterRt(IDEX_RegisterRt),
        .IFID_Rs        (IFID_Rs),
        .IFID_Rt        (IFID_Rt),
        .IFID_UsesRt    (IFID_UsesRt),
        .IFID_UsesHiLo  (IFID_UsesHiLo),
        .IFID_IsMult    (IFID_IsMult),
        .EX_MultStart   (EX_MultStart),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFIDFlush      (IFIDFlush),
        .IDEXBubble     (IDEXBubble),
        .MultBusy       (MultBusy),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: remaining busy cycles of the multiplier and plain counters.
    int busyLeft = 0;
    int stallCnt = 0;
    int flushCnt = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rstn      = ($urandom_range(0, 49) != 0);
        s.memRead   = 1'($urandom_range(0, 1));
        s.idexRt    = 5'($urandom_range(0, 3));
        s.rs        = 5'($urandom_range(0, 3));
        s.rt        = 5'($urandom_range(0, 3));
        s.usesRt    = 1'($urandom_range(0, 1));
        s.usesHiLo  = ($urandom_range(0, 3) == 0);
        s.isMult    = ($urandom_range(0, 3) == 0);
        s.multStart = ($urandom_range(0, 7) == 0);
        s.branch    = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    // Drive one cycle, push the model's expectation, then advance the model
    // across the coming rising edge.
    task automatic step(input stim_t s);
        exp_t e;
        bit   busy;
        bit   lu;
        bit   ml;
        @(negedge Clk);
        Rst_n           = s.rstn;
        IDEX_MemRead    = s.memRead;
        IDEX_RegisterRt = s.idexRt;
        IFID_Rs         = s.rs;
        IFID_Rt         = s.rt;
        IFID_UsesRt     = s.usesRt;
        IFID_UsesHiLo   = s.usesHiLo;
        IFID_IsMult     = s.isMult;
        EX_MultStart    = s.multStart;
        EX_BranchTaken  = s.branch;
        #1;
        if (!s.rstn) begin
            busyLeft = 0;
            stallCnt = 0;
            flushCnt = 0;
            e.ctl   = 5'b00010;
            e.stall = '0;
            e.flush = '0;
            expQ.push_back(e);
        end else begin
            busy = (busyLeft > 0);
            lu   = s.memRead && (s.idexRt != 0)
                   && ((s.idexRt == s.rs) || (s.usesRt && (s.idexRt == s.rt)));
            ml   = busy && (s.usesHiLo || s.isMult);
            if (s.branch)     e.ctl = {4'b1111, busy};
            else if (lu || ml) e.ctl = {4'b0001, busy};
            else              e.ctl = {4'b1100, busy};
            e.stall = CW'(stallCnt);
            e.flush = CW'(flushCnt);
            expQ.push_back(e);
            if (s.branch) begin
                if (flushCnt < MAXC) flushCnt++;
            end else if (lu || ml) begin
                if (stallCnt < MAXC) stallCnt++;
            end
            if (s.multStart)      busyLeft = ML;
            else if (busyLeft > 0) busyLeft--;
        end
    endtask

    // Monitor: compare mid-cycle, after stimulus has settled, before the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #3;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if ({PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MultBusy} !== e.ctl)
                    $display("FAIL strobes t=%0t got {pc,ifw,fl,bub,busy}=%b required %b",
                             $time, {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MultBusy}, e.ctl);
                else passes++;
                checks++;
                if (StallCycles !== e.stall)
                    $display("FAIL StallCycles t=%0t got %0d required %0d", $time, StallCycles, e.stall);
                else passes++;
                checks++;
                if (FlushCount !== e.flush)
                    $display("FAIL FlushCount t=%0t got %0d required %0d", $time, FlushCount, e.flush);
                else passes++;
            end
        end
    end

    initial begin
        stim_t s;
        Rst_n = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegisterRt = '0; IFID_Rs = '0; IFID_Rt = '0;
        IFID_UsesRt = 1'b0; IFID_UsesHiLo = 1'b0; IFID_IsMult = 1'b0;
        EX_MultStart = 1'b0; EX_BranchTaken = 1'b0;

        // Reset held with random inputs, then release.
        for (int i = 0; i < 3; i++) begin
            s = randStim();
            s.rstn = 1'b0;
            step(s);
        end
        step(idle());
        step(idle());

        // Load-use on rs: one stall.
        s = idle(); s.memRead = 1'b1; s.idexRt = 5'd8; s.rs = 5'd8;
        step(s);
        step(idle());
        // Match on rt but rt is not a source: no stall.
        s = idle(); s.memRead = 1'b1; s.idexRt = 5'd8; s.rt = 5'd8; s.rs = 5'd3;
        step(s);
        // Load into $0: no stall.
        s = idle(); s.memRead = 1'b1; s.idexRt = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.usesRt = 1'b1;
        step(s);

        // Mult lock: four busy stall cycles, then proceed.
        s = idle(); s.multStart = 1'b1;
        step(s);
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.usesHiLo = 1'b1;
            step(s);
        end

        // Branch over a load-use hazard.
        s = idle(); s.branch = 1'b1; s.memRead = 1'b1; s.idexRt = 5'd5; s.rs = 5'd5;
        step(s);
        step(idle());

        // Reset in the middle of a multiply.
        s = idle(); s.multStart = 1'b1;
        step(s);
        step(idle());
        step(idle());
        s = idle(); s.rstn = 1'b0; s.isMult = 1'b1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.isMult = 1'b1;
            step(s);
        end

        // Sustained mult lock drives StallCycles into saturation.
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.usesHiLo = 1'b1; s.multStart = (i % 3 == 0);
            step(s);
        end
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.branch = 1'b1;
            step(s);
        end

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(randStim());
        end
        step(idle());

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge Clk);
        #4;
        if (expQ.size() > 0) begin
            checks++;
            $display("FAIL drain got %0d entries left required 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
